// File: rtl/lsq_mem_pkg.sv
// lsq_mem_pkg: shared types and helpers for the LSQ memory sequencer.
//   lsq_state_e      - sequencer FSM states (IDLE, XFER, DRAIN, RESP)
//   SZ_*             - request size encodings (byte, half, word, word)
//   last_byte_idx()  - index of the final byte lane for a size
//   is_misaligned()  - natural-alignment check for a size/address pair
package lsq_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_XFER  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_RESP  = 2'b11
  } lsq_state_e;

  localparam logic [1:0] SZ_BYTE     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_WORD     = 2'b10;
  localparam logic [1:0] SZ_WORD_ALT = 2'b11;

  // Access length is N = 1/2/4 bytes; this returns N-1.
  function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
    case (size)
      SZ_BYTE: last_byte_idx = 2'd0;
      SZ_HALF: last_byte_idx = 2'd1;
      default: last_byte_idx = 2'd3;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      default: is_misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/lsq_mem_seq_load_byte_assembler.sv
// load_byte_assembler: collects load bytes into four lanes and extends them.
//   clk, rst       - clock, asynchronous active-low reset
//   clear          - zero all lanes (new request accepted)
//   issue_en/lane  - a read for byte lane 'issue_lane' is on the bus this cycle
//   rdata          - memory read byte, valid the cycle after the read
//   size, sign_ext - access size and sign-extension enable
//   data           - extended load value, including the byte arriving this cycle
module load_byte_assembler
  import lsq_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        issue_en,
  input  logic [1:0]  issue_lane,
  input  logic [7:0]  rdata,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [3:0][7:0] lanes_q, lanes_d;
  logic            pend_q, pend_d;
  logic [1:0]      pend_lane_q, pend_lane_d;

  // Reads return one cycle late, so remember which lane the read was for.
  always_comb begin
    lanes_d     = lanes_q;
    pend_d      = issue_en;
    pend_lane_d = issue_lane;
    if (pend_q) begin
      lanes_d[pend_lane_q] = rdata;
    end
    if (clear) begin
      lanes_d = '0;
      pend_d  = 1'b0;
    end
  end

  // Output is taken from lanes_d so the final byte can be registered into
  // the response on the same edge it is captured.
  always_comb begin
    case (size)
      SZ_BYTE: data = {{24{sign_ext & lanes_d[0][7]}}, lanes_d[0]};
      SZ_HALF: data = {{16{sign_ext & lanes_d[1][7]}}, lanes_d[1], lanes_d[0]};
      default: data = lanes_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lanes_q     <= '0;
      pend_q      <= 1'b0;
      pend_lane_q <= '0;
    end else begin
      lanes_q     <= lanes_d;
      pend_q      <= pend_d;
      pend_lane_q <= pend_lane_d;
    end
  end

endmodule

// File: rtl/lsq_mem_seq.sv
// lsq_mem_seq: serialises LSQ load/store requests onto a byte-wide
// single-port memory, one byte per cycle, little-endian.
//   clk, rst                     - clock, asynchronous active-low reset
//   req_valid/req_ready          - request handshake (ready only in IDLE)
//   req_store/size/signed/addr/data/tag - request fields
//   flush                        - squash an in-flight load
//   mem_re/mem_wr/mem_address/mem_wdata/mem_rdata - memory port
//   resp_valid/tag/data/store/err - one-cycle completion pulse
// Optional feature: define LSQ_MEM_MISALIGN_CHECK_EN to reject misaligned
// half/word accesses with resp_err instead of performing them bytewise.
module lsq_mem_seq
  import lsq_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned TAG_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic              mem_re,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              resp_valid,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [31:0]       resp_data,
  output logic              resp_store,
  output logic              resp_err
);

  lsq_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d, cnt_nxt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;

  logic              req_ready_q, req_ready_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              resp_store_q, resp_store_d;
  logic              resp_err_q, resp_err_d;

  logic              asm_clear;
  logic [31:0]       asm_data;

  if (ADDR_W < 32) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W];
  end

  load_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .issue_en   (mem_re_q),
    .issue_lane (cnt_q),
    .rdata      (mem_rdata),
    .size       (size_q),
    .sign_ext   (signed_q),
    .data       (asm_data)
  );

  // All bus/response outputs are registered, so each is computed one cycle
  // ahead from the transition being taken.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    tag_d         = tag_q;
    store_d       = store_q;
    size_d        = size_q;
    signed_d      = signed_q;
    req_ready_d   = 1'b0;
    mem_re_d      = 1'b0;
    mem_wr_d      = 1'b0;
    mem_address_d = '0;
    mem_wdata_d   = '0;
    resp_valid_d  = 1'b0;
    resp_tag_d    = '0;
    resp_data_d   = '0;
    resp_store_d  = 1'b0;
    resp_err_d    = 1'b0;
    asm_clear     = 1'b0;
    cnt_nxt       = cnt_q + 2'd1;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          asm_clear = 1'b1;
          cnt_d     = '0;
          addr_d    = req_addr[ADDR_W-1:0];
          wdata_d   = req_data;
          tag_d     = req_tag;
          store_d   = req_store;
          size_d    = req_size;
          signed_d  = req_signed;
`ifdef LSQ_MEM_MISALIGN_CHECK_EN
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_tag_d   = req_tag;
            resp_store_d = req_store;
          end else
`endif
          begin
            state_d       = ST_XFER;
            mem_re_d      = ~req_store;
            mem_wr_d      = req_store;
            mem_address_d = req_addr[ADDR_W-1:0];
            mem_wdata_d   = req_store ? req_data[7:0] : 8'h00;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end

      ST_XFER: begin
        if (!store_q && flush) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
        end else if (cnt_q == last_byte_idx(size_q)) begin
          if (store_q) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_tag_d   = tag_q;
            resp_store_d = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          cnt_d         = cnt_nxt;
          mem_re_d      = ~store_q;
          mem_wr_d      = store_q;
          mem_address_d = addr_q + ADDR_W'(cnt_nxt);
          mem_wdata_d   = store_q ? wdata_q[{cnt_nxt, 3'b000} +: 8] : 8'h00;
        end
      end

      ST_DRAIN: begin
        if (flush) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_tag_d   = tag_q;
          resp_data_d  = asm_data;
        end
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      tag_q         <= '0;
      store_q       <= 1'b0;
      size_q        <= '0;
      signed_q      <= 1'b0;
      req_ready_q   <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_tag_q    <= '0;
      resp_data_q   <= '0;
      resp_store_q  <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      tag_q         <= tag_d;
      store_q       <= store_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      req_ready_q   <= req_ready_d;
      mem_re_q      <= mem_re_d;
      mem_wr_q      <= mem_wr_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      resp_valid_q  <= resp_valid_d;
      resp_tag_q    <= resp_tag_d;
      resp_data_q   <= resp_data_d;
      resp_store_q  <= resp_store_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign mem_re      = mem_re_q;
  assign mem_wr      = mem_wr_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign resp_valid  = resp_valid_q;
  assign resp_tag    = resp_tag_q;
  assign resp_data   = resp_data_q;
  assign resp_store  = resp_store_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_lsq_mem_seq.sv
// tb_lsq_mem_seq: directed bench for lsq_mem_seq with a sparse byte memory.
module tb_lsq_mem_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [5:0]  req_tag;
  logic        flush;
  logic        mem_re;
  logic        mem_wr;
  logic [19:0] mem_address;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        resp_valid;
  logic [5:0]  resp_tag;
  logic [31:0] resp_data;
  logic        resp_store;
  logic        resp_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem [logic [19:0]];
  logic [7:0]  st_bytes [4];
  logic [19:0] wrap_addr [4];

  always #5 clk = ~clk;

  lsq_mem_seq #(.ADDR_W(20), .TAG_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_store   (req_store),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_tag     (req_tag),
    .flush       (flush),
    .mem_re      (mem_re),
    .mem_wr      (mem_wr),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .resp_valid  (resp_valid),
    .resp_tag    (resp_tag),
    .resp_data   (resp_data),
    .resp_store  (resp_store),
    .resp_err    (resp_err)
  );

  // Memory returns the addressed byte the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_re && mem.exists(mem_address)) mem_rdata <= mem[mem_address];
    else                                   mem_rdata <= 8'h00;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drives a request for the handshake cycle; returns in cycle 1.
  task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d, input logic [5:0] t);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_data   = d;
    req_tag    = t;
    tick();
    req_valid  = 1'b0;
  endtask

  initial begin
    st_bytes  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wrap_addr = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
    mem[20'h00010] = 8'h80;
    mem[20'hFFFFE] = 8'h11;
    mem[20'hFFFFF] = 8'h22;
    mem[20'h00000] = 8'h33;
    mem[20'h00001] = 8'h44;
    mem[20'h00020] = 8'h34;
    mem[20'h00021] = 8'hA5;
    mem[20'h00003] = 8'h9C;
    mem[20'h00004] = 8'h12;

    rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_data = '0; req_tag = '0; flush = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Word store; req_valid held with other fields while busy must be ignored
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEADBEEF, 6'd5);
    req_valid = 1'b1; req_data = 32'h0123_4567; req_addr = 32'h0000_0FF0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("st_wr%0d", k), 32'(mem_wr), 32'd1);
      chk($sformatf("st_re%0d", k), 32'(mem_re), 32'd0);
      chk($sformatf("st_addr%0d", k), 32'(mem_address), 32'h100 + 32'(k));
      chk($sformatf("st_byte%0d", k), 32'(mem_wdata), 32'(st_bytes[k]));
      chk($sformatf("st_busy_ready%0d", k), 32'(req_ready), 32'd0);
      if (k == 3) req_valid = 1'b0;
      tick();
    end
    chk("st_resp_valid", 32'(resp_valid), 32'd1);
    chk("st_resp_store", 32'(resp_store), 32'd1);
    chk("st_resp_tag", 32'(resp_tag), 32'd5);
    chk("st_resp_data", resp_data, 32'd0);
    chk("st_resp_err", 32'(resp_err), 32'd0);
    chk("st_wr_done", 32'(mem_wr), 32'd0);
    tick();
    chk("st_resp_pulse", 32'(resp_valid), 32'd0);

    // Signed byte load of 0x80
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'd0, 6'd7);
    chk("lb_re", 32'(mem_re), 32'd1);
    chk("lb_addr", 32'(mem_address), 32'h10);
    chk("lb_wr", 32'(mem_wr), 32'd0);
    tick();
    chk("lb_drain_re", 32'(mem_re), 32'd0);
    chk("lb_drain_resp", 32'(resp_valid), 32'd0);
    tick();
    chk("lb_resp_valid", 32'(resp_valid), 32'd1);
    chk("lb_resp_data", resp_data, 32'hFFFF_FF80);
    chk("lb_resp_store", 32'(resp_store), 32'd0);
    chk("lb_resp_tag", 32'(resp_tag), 32'd7);
    tick();

    // Unsigned byte load of 0x80
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'd0, 6'd8);
    tick(); tick();
    chk("lbu_resp_valid", 32'(resp_valid), 32'd1);
    chk("lbu_resp_data", resp_data, 32'h0000_0080);
    tick();

    // Word load wrapping across the top of the address space
    issue(1'b0, 2'b10, 1'b0, 32'h000F_FFFE, 32'd0, 6'd9);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lw_re%0d", k), 32'(mem_re), 32'd1);
      chk($sformatf("lw_addr%0d", k), 32'(mem_address), 32'(wrap_addr[k]));
      tick();
    end
    chk("lw_drain_re", 32'(mem_re), 32'd0);
    chk("lw_drain_resp", 32'(resp_valid), 32'd0);
    tick();
    chk("lw_resp_valid", 32'(resp_valid), 32'd1);
    chk("lw_resp_data", resp_data, 32'h4433_2211);
    tick();

    // Signed half load with negative top byte
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0020, 32'd0, 6'd10);
    tick(); tick(); tick();
    chk("lh_resp_valid", 32'(resp_valid), 32'd1);
    chk("lh_resp_data", resp_data, 32'hFFFF_A534);
    tick();

    // Misaligned half load at 0x00003
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'd0, 6'd11);
`ifdef LSQ_MEM_MISALIGN_CHECK_EN
    chk("mis_re", 32'(mem_re), 32'd0);
    chk("mis_resp_valid", 32'(resp_valid), 32'd1);
    chk("mis_resp_err", 32'(resp_err), 32'd1);
    chk("mis_resp_data", resp_data, 32'd0);
    chk("mis_resp_tag", 32'(resp_tag), 32'd11);
    tick();
    chk("mis_ready", 32'(req_ready), 32'd1);
`else
    chk("mis_re", 32'(mem_re), 32'd1);
    chk("mis_addr0", 32'(mem_address), 32'h3);
    tick();
    chk("mis_addr1", 32'(mem_address), 32'h4);
    tick(); tick();
    chk("mis_resp_valid", 32'(resp_valid), 32'd1);
    chk("mis_resp_err", 32'(resp_err), 32'd0);
    chk("mis_resp_data", resp_data, 32'h0000_129C);
    tick();
`endif

    // Flush in cycle 2 of a word load
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0, 6'd12);
    chk("fl_re1", 32'(mem_re), 32'd1);
    tick();
    chk("fl_re2", 32'(mem_re), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_re3", 32'(mem_re), 32'd0);
    chk("fl_ready3", 32'(req_ready), 32'd1);
    chk("fl_resp3", 32'(resp_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("fl_quiet_resp%0d", k), 32'(resp_valid), 32'd0);
      chk($sformatf("fl_quiet_re%0d", k), 32'(mem_re), 32'd0);
    end

    // Half store with flush held high throughout must still complete
    flush = 1'b1;
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0200, 32'h0000_1234, 6'd13);
    chk("sh_wr0", 32'(mem_wr), 32'd1);
    chk("sh_byte0", 32'(mem_wdata), 32'h34);
    tick();
    chk("sh_addr1", 32'(mem_address), 32'h201);
    chk("sh_byte1", 32'(mem_wdata), 32'h12);
    tick();
    chk("sh_resp_valid", 32'(resp_valid), 32'd1);
    chk("sh_resp_store", 32'(resp_store), 32'd1);
    chk("sh_resp_tag", 32'(resp_tag), 32'd13);
    flush = 1'b0;
    tick();

    // Reset asserted in cycle 2 of a word store
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 6'd14);
    chk("rs_wr1", 32'(mem_wr), 32'd1);
    tick();
    chk("rs_wr2", 32'(mem_wr), 32'd1);
    rst = 1'b0;
    #1;
    chk("rs_wr_async", 32'(mem_wr), 32'd0);
    chk("rs_addr_async", 32'(mem_address), 32'd0);
    chk("rs_ready_async", 32'(req_ready), 32'd0);
    tick(); tick();
    chk("rs_resp_held", 32'(resp_valid), 32'd0);
    rst = 1'b1;
    tick();
    chk("rs_ready_after", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rs_no_resp%0d", k), 32'(resp_valid), 32'd0);
      chk($sformatf("rs_no_wr%0d", k), 32'(mem_wr), 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
